// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory frame loader.
package loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WR, CSUM, DONE, ERR} loader_state_t;
  localparam logic [7:0] HDR_DEFAULT = 8'hA5;
  localparam int FRAME_LEN_W = 16;
endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs four stream bytes into a little-endian word; word_next already includes the byte being loaded.
// Holds only one word, so the owner must take word_next on the cycle word_full is high.
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_full
);
  logic [31:0] word_q;
  logic [1:0]  lane;

  always_comb begin
    word_next = word_q;
    word_next[{lane, 3'b000} +: 8] = byte_in;
  end

  assign word_full = load && (lane == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q <= '0;
      lane   <= '0;
    end else if (clear) begin
      word_q <= '0;
      lane   <= '0;
    end else if (load) begin
      word_q <= word_next;
      lane   <= lane + 2'd1;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Writes a checksummed byte frame into instruction memory and keeps the core in reset until one loads cleanly.
// iwe one cycle after a word's 4th byte, done/err one cycle after CSUM; in_ready drops only for the WR cycle.
module imem_loader
  import loader_pkg::*;
#(
  parameter int         DEPTH  = 64,
  parameter int         ADDR_W = 6,
  parameter logic [7:0] HDR    = HDR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              iwe,
  output logic [ADDR_W-1:0] iaddr,
  output logic [31:0]       iwdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err
);
  localparam logic [FRAME_LEN_W-1:0] MAX_LEN = FRAME_LEN_W'(DEPTH);

  loader_state_t          state;
  logic [FRAME_LEN_W-1:0] len;
  logic [FRAME_LEN_W-1:0] word_cnt;
  logic [FRAME_LEN_W-1:0] word_cnt_nxt;
  logic [FRAME_LEN_W-1:0] len_full;
  logic [7:0]             sum;
  logic                   accept;
  logic                   start;
  logic                   load;
  logic                   word_full;
  logic [31:0]            word_next;

  assign accept       = in_valid & in_ready;
  // A header only opens a frame between frames; inside one it is plain data.
  assign start        = accept && (in_data == HDR) &&
                        (state == IDLE || state == DONE || state == ERR);
  assign load         = accept && (state == DATA);
  assign len_full     = {in_data, len[7:0]};
  assign word_cnt_nxt = word_cnt + FRAME_LEN_W'(1);

  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (start),
    .load      (load),
    .byte_in   (in_data),
    .word_next (word_next),
    .word_full (word_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      iwe       <= 1'b0;
      iaddr     <= '0;
      iwdata    <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      len       <= '0;
      word_cnt  <= '0;
      sum       <= '0;
    end else begin
      iwe      <= 1'b0;
      in_ready <= 1'b1;
      if (start) begin
        state     <= LEN0;
        sum       <= '0;
        word_cnt  <= '0;
        done      <= 1'b0;
        err       <= 1'b0;
        cpu_reset <= 1'b1;
      end
      case (state)
        LEN0: if (accept) begin
          len[7:0] <= in_data;
          state    <= LEN1;
        end
        LEN1: if (accept) begin
          len[15:8] <= in_data;
          if (len_full > MAX_LEN) begin
            state <= ERR;
            err   <= 1'b1;
          end else if (len_full == '0) begin
            state <= CSUM;
          end else begin
            state <= DATA;
          end
        end
        DATA: if (accept) begin
          sum <= sum + in_data;
          if (word_full) begin
            state    <= WR;
            iwe      <= 1'b1;
            in_ready <= 1'b0;
            iaddr    <= word_cnt[ADDR_W-1:0];
            iwdata   <= word_next;
          end
        end
        WR: begin
          word_cnt <= word_cnt_nxt;
          state    <= (word_cnt_nxt == len) ? CSUM : DATA;
        end
        CSUM: if (accept) begin
          if (in_data == sum) begin
            state     <= DONE;
            done      <= 1'b1;
            cpu_reset <= 1'b0;
          end else begin
            state <= ERR;
            err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: constant vectors, hand-timed corner sequences and random frames against a frame parser model.
module tb_imem_loader;
  import loader_pkg::*;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  typedef struct {
    string        name;
    int           nb;
    logic [127:0] bytes;
    logic         exp_done;
    logic         exp_err;
    int           exp_nwr;
    logic [31:0]  exp_w0;
    logic [31:0]  exp_wl;
    bit           gaps;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready, iwe, cpu_reset, done, err;
  logic [ADDR_W-1:0] iaddr;
  logic [31:0]       iwdata;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  byte_q[$];
  int          got_a[$];
  logic [31:0] got_d[$];
  int          exp_a[$];
  logic [31:0] exp_d[$];
  int          st = 0;  // 0: nothing loaded, 1: last frame good, 2: last frame rejected

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HDR(8'hA5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .iwe       (iwe),
    .iaddr     (iaddr),
    .iwdata    (iwdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (iwe) begin
      got_a.push_back(int'(iaddr));
      got_d.push_back(iwdata);
      check("ready_low_during_write", 32'(in_ready), 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int waited = 0;
    if (gaps) begin
      in_data = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake_timeout: in_ready stuck at 0, required 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_queue(input bit gaps);
    for (int i = 0; i < byte_q.size(); i++) send_byte(byte_q[i], gaps);
  endtask

  // Parses the whole byte stream as frames and derives the writes and final status.
  task automatic run_model();
    int i = 0;
    int n;
    int s;
    exp_a.delete();
    exp_d.delete();
    while (i < byte_q.size()) begin
      if (byte_q[i] != 8'hA5) begin
        i++;
        continue;
      end
      if (i + 2 >= byte_q.size()) break;
      n = int'(byte_q[i+1]) + 256 * int'(byte_q[i+2]);
      i += 3;
      if (n > DEPTH) begin
        st = 2;
        continue;
      end
      s = 0;
      for (int k = 0; k < n; k++) begin
        exp_a.push_back(k);
        exp_d.push_back({byte_q[i+3], byte_q[i+2], byte_q[i+1], byte_q[i]});
        for (int j = 0; j < 4; j++) s += int'(byte_q[i+j]);
        i += 4;
      end
      st = ((s % 256) == int'(byte_q[i])) ? 1 : 2;
      i++;
    end
  endtask

  task automatic build_frame(input int n, input bit bad);
    int s = 0;
    logic [7:0] b;
    byte_q.push_back(8'hA5);
    byte_q.push_back(8'(n));
    byte_q.push_back(8'(n >> 8));
    for (int k = 0; k < 4 * n; k++) begin
      b = 8'($urandom);
      s += int'(b);
      byte_q.push_back(b);
    end
    byte_q.push_back(8'(s) + 8'(bad));
  endtask

  task automatic compare_run(input string name);
    check({name, "_nwr"}, 32'(got_a.size()), 32'(exp_a.size()));
    for (int k = 0; k < exp_a.size() && k < got_a.size(); k++) begin
      check({name, "_addr"}, 32'(got_a[k]), 32'(exp_a[k]));
      check({name, "_data"}, got_d[k], exp_d[k]);
    end
    check({name, "_done"}, 32'(done), 32'(st == 1));
    check({name, "_err"}, 32'(err), 32'(st == 2));
    check({name, "_cpu_reset"}, 32'(cpu_reset), 32'(st != 1));
    check({name, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic load_basic();
    byte_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00,
               8'h93, 8'h05, 8'h60, 8'h00, 8'h60};
  endtask

  initial begin
    vec_t vecs[6];
    logic [7:0] b;
    // Data bytes 13 05 50 00 93 05 60 00 sum to 0x160, so 0x60 is the good checksum.
    vecs[0] = '{"basic",    12, 128'hA5_02_00_13_05_50_00_93_05_60_00_60, 1'b1, 1'b0, 2, 32'h00500513, 32'h00600593, 1'b0};
    vecs[1] = '{"bad_csum", 12, 128'hA5_02_00_13_05_50_00_93_05_60_00_5F, 1'b0, 1'b1, 2, 32'h00500513, 32'h00600593, 1'b0};
    vecs[2] = '{"oversize",  3, 128'hA5_41_00,                            1'b0, 1'b1, 0, 32'h0, 32'h0, 1'b0};
    vecs[3] = '{"empty",     4, 128'hA5_00_00_00,                         1'b1, 1'b0, 0, 32'h0, 32'h0, 1'b0};
    vecs[4] = '{"garbage",   3, 128'h00_FF_7E,                            1'b1, 1'b0, 0, 32'h0, 32'h0, 1'b0};
    vecs[5] = '{"gaps",     12, 128'hA5_02_00_13_05_50_00_93_05_60_00_60, 1'b1, 1'b0, 2, 32'h00500513, 32'h00600593, 1'b1};

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_iwe", 32'(iwe), 32'd0);
    check("rst_iaddr", 32'(iaddr), 32'd0);
    check("rst_iwdata", iwdata, 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(in_ready), 32'd1);

    // Cycle-exact latencies on the basic frame, valid held high throughout.
    load_basic();
    for (int k = 0; k < 7; k++) send_byte(byte_q[k], 1'b0);
    check("lat_w0_iwe", 32'(iwe), 32'd1);
    check("lat_w0_ready", 32'(in_ready), 32'd0);
    check("lat_w0_addr", 32'(iaddr), 32'd0);
    check("lat_w0_data", iwdata, 32'h00500513);
    send_byte(byte_q[7], 1'b0);
    check("hold_iwe", 32'(iwe), 32'd0);
    check("hold_addr", 32'(iaddr), 32'd0);
    check("hold_data", iwdata, 32'h00500513);
    for (int k = 8; k < 11; k++) send_byte(byte_q[k], 1'b0);
    check("lat_w1_iwe", 32'(iwe), 32'd1);
    check("lat_w1_addr", 32'(iaddr), 32'd1);
    check("lat_w1_data", iwdata, 32'h00600593);
    check("pre_csum_done", 32'(done), 32'd0);
    send_byte(byte_q[11], 1'b0);
    check("lat_done", 32'(done), 32'd1);
    check("lat_cpu_reset", 32'(cpu_reset), 32'd0);
    check("lat_err", 32'(err), 32'd0);
    st = 1;

    for (int v = 0; v < 6; v++) begin
      byte_q.delete();
      for (int k = 0; k < vecs[v].nb; k++) byte_q.push_back(vecs[v].bytes[8*(vecs[v].nb-1-k) +: 8]);
      run_model();
      got_a.delete();
      got_d.delete();
      send_queue(vecs[v].gaps);
      check({vecs[v].name, "_tbl_done"}, 32'(done), 32'(vecs[v].exp_done));
      check({vecs[v].name, "_tbl_err"}, 32'(err), 32'(vecs[v].exp_err));
      check({vecs[v].name, "_tbl_cpu_reset"}, 32'(cpu_reset), 32'(!vecs[v].exp_done));
      check({vecs[v].name, "_tbl_nwr"}, 32'(got_d.size()), 32'(vecs[v].exp_nwr));
      if (vecs[v].exp_nwr > 0 && got_d.size() > 0) begin
        check({vecs[v].name, "_tbl_w0"}, got_d[0], vecs[v].exp_w0);
        check({vecs[v].name, "_tbl_wl"}, got_d[got_d.size()-1], vecs[v].exp_wl);
      end
      compare_run(vecs[v].name);
    end

    // Garbage after a good load, then a reload.
    byte_q = '{8'h00, 8'hFF, 8'h7E};
    send_queue(1'b0);
    check("garbage_done", 32'(done), 32'd1);
    check("garbage_cpu_reset", 32'(cpu_reset), 32'd0);
    load_basic();
    run_model();
    got_a.delete();
    got_d.delete();
    send_byte(byte_q[0], 1'b0);
    check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
    check("reload_done_cleared", 32'(done), 32'd0);
    for (int k = 1; k < byte_q.size(); k++) send_byte(byte_q[k], 1'b0);
    compare_run("reload");

    // Asynchronous reset after two data bytes.
    load_basic();
    for (int k = 0; k < 5; k++) send_byte(byte_q[k], 1'b0);
    #2 reset = 1'b0;
    #1;
    check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_iwe", 32'(iwe), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    st = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_model();
    got_a.delete();
    got_d.delete();
    send_queue(1'b1);
    compare_run("after_reset");

    // Largest legal frame fills every address.
    byte_q.delete();
    build_frame(DEPTH, 1'b0);
    run_model();
    got_a.delete();
    got_d.delete();
    send_queue(1'b0);
    compare_run("full_depth");

    for (int r = 0; r < 10; r++) begin
      byte_q.delete();
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        byte_q.push_back(b);
      end
      build_frame($urandom_range(0, 8), $urandom_range(0, 3) == 0);
      run_model();
      got_a.delete();
      got_d.delete();
      send_queue($urandom_range(0, 1) == 1);
      compare_run("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
